// File: rtl/instr_fetch.sv
// Instruction fetch stage: owns the PC, fetches words over a req/ack memory handshake
// and hands one instruction at a time to decode, applying jump/branch redirects.
module instr_fetch #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst_n,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ack,
    input  logic [31:0] imem_rdata,
    output logic        if_valid,
    input  logic        if_ready,
    output logic [31:0] if_instr,
    output logic [5:0]  if_opcode,
    output logic [31:0] if_pc4,
    input  logic        br_take,
    input  logic [15:0] br_imm,
    input  logic        jump,
    input  logic [25:0] jump_idx
);
    // Handshakes: memory transfers when imem_req & imem_ack (req and addr held until ack);
    // decode transfers when if_valid & if_ready (outputs held stable until then).
    typedef enum logic [1:0] {IDLE, FETCH, HOLD} state_t;

    state_t      state;
    logic [31:0] pc;
    logic [31:0] last_pc4;
    logic        kill;

    logic        redirect;
    logic        transfer;
    logic [31:0] br_off;
    logic [31:0] target;
    logic [31:0] pc_inc;

    assign redirect  = jump | br_take;
    assign transfer  = if_valid & if_ready;
    assign br_off    = {{14{br_imm[15]}}, br_imm, 2'b00};
    assign target    = jump ? {last_pc4[31:28], jump_idx, 2'b00} : last_pc4 + br_off;
    assign pc_inc    = pc + 32'd4;
    assign if_opcode = if_instr[31:26];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            pc        <= RESET_PC;
            imem_req  <= 1'b0;
            imem_addr <= RESET_PC;
            if_valid  <= 1'b0;
            if_instr  <= 32'd0;
            if_pc4    <= 32'd0;
            kill      <= 1'b0;
            last_pc4  <= 32'd0;
        end else begin
            case (state)
                IDLE: begin
                    state    <= FETCH;
                    imem_req <= 1'b1;
                    if (redirect) begin
                        pc        <= target;
                        imem_addr <= target;
                    end else begin
                        imem_addr <= pc;
                    end
                end
                FETCH: begin
                    if (imem_ack) begin
                        if (redirect) begin
                            pc        <= target;
                            imem_addr <= target;
                            kill      <= 1'b0;
                        end else if (kill) begin
                            // pc already holds the redirect target from the earlier cycle
                            kill      <= 1'b0;
                            imem_addr <= pc;
                        end else begin
                            if_instr <= imem_rdata;
                            if_pc4   <= pc_inc;
                            if_valid <= 1'b1;
                            pc       <= pc_inc;
                            imem_req <= 1'b0;
                            state    <= HOLD;
                        end
                    end else if (redirect) begin
                        // address must stay put until the ack, so mark the data stale
                        pc   <= target;
                        kill <= 1'b1;
                    end
                end
                HOLD: begin
                    if (transfer) last_pc4 <= if_pc4;
                    if (redirect || transfer) begin
                        if_valid <= 1'b0;
                        state    <= FETCH;
                        imem_req <= 1'b1;
                        if (redirect) begin
                            pc        <= target;
                            imem_addr <= target;
                        end else begin
                            imem_addr <= pc;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_instr_fetch.sv
// Self-checking bench for instr_fetch: memory responder, decode-side driver and a
// scoreboard of {instr, pc4} pushed at memory ack and popped at decode transfer.
module tb_instr_fetch;
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        imem_req, imem_ack = 1'b0;
    logic [31:0] imem_addr, imem_rdata = 32'd0;
    logic        if_valid, if_ready = 1'b0;
    logic [31:0] if_instr, if_pc4;
    logic [5:0]  if_opcode;
    logic        br_take = 1'b0, jump = 1'b0;
    logic [15:0] br_imm = 16'd0;
    logic [25:0] jump_idx = 26'd0;

    logic        w_req, w_valid, w_ready = 1'b0;
    logic [31:0] w_addr, w_instr, w_pc4, w_rdata;
    logic [5:0]  w_opcode;

    int n_vec = 0;
    int n_err = 0;
    logic [63:0] exp_q[$];

    always #5 clk = ~clk;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        if (a == 32'd0) return 32'h8C01_0004;
        return (a * 32'h9E37_79B1) ^ 32'h1234_5678;
    endfunction

    instr_fetch u_dut (
        .clk(clk), .rst_n(rst_n),
        .imem_req(imem_req), .imem_addr(imem_addr), .imem_ack(imem_ack), .imem_rdata(imem_rdata),
        .if_valid(if_valid), .if_ready(if_ready), .if_instr(if_instr), .if_opcode(if_opcode),
        .if_pc4(if_pc4), .br_take(br_take), .br_imm(br_imm), .jump(jump), .jump_idx(jump_idx)
    );

    assign w_rdata = mem_word(w_addr);
    instr_fetch #(.RESET_PC(32'hFFFF_FFFC)) u_wrap (
        .clk(clk), .rst_n(rst_n),
        .imem_req(w_req), .imem_addr(w_addr), .imem_ack(w_req), .imem_rdata(w_rdata),
        .if_valid(w_valid), .if_ready(w_ready), .if_instr(w_instr), .if_opcode(w_opcode),
        .if_pc4(w_pc4), .br_take(1'b0), .br_imm(16'd0), .jump(1'b0), .jump_idx(26'd0)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic wait_req();
        int n = 0;
        while (imem_req !== 1'b1 && n < 20) begin
            @(negedge clk);
            n++;
        end
        check("req_wait", {31'd0, imem_req}, 32'd1);
    endtask

    // Fetch one word at addr after lat stall cycles, hold it hold cycles, then transfer.
    task automatic fetch_xfer(input logic [31:0] addr, input int lat, input int hold);
        logic [63:0] e;
        wait_req();
        check("fetch_addr", imem_addr, addr);
        for (int i = 0; i < lat; i++) begin
            imem_ack = 1'b0;
            @(negedge clk);
            check("addr_stable", imem_addr, addr);
        end
        imem_ack   = 1'b1;
        imem_rdata = mem_word(addr);
        exp_q.push_back({mem_word(addr), addr + 32'd4});
        @(negedge clk);
        imem_ack = 1'b0;
        check("valid_up", {31'd0, if_valid}, 32'd1);
        check("req_off", {31'd0, imem_req}, 32'd0);
        e = exp_q[0];
        for (int i = 0; i < hold; i++) begin
            @(negedge clk);
            check("hold_valid", {31'd0, if_valid}, 32'd1);
            check("hold_req", {31'd0, imem_req}, 32'd0);
            check("hold_instr", if_instr, e[63:32]);
            check("hold_pc4", if_pc4, e[31:0]);
        end
        if_ready = 1'b1;
        e = exp_q.pop_front();
        check("xfer_instr", if_instr, e[63:32]);
        check("xfer_opcode", {26'd0, if_opcode}, {26'd0, e[63:58]});
        check("xfer_pc4", if_pc4, e[31:0]);
        @(negedge clk);
        if_ready = 1'b0;
        check("valid_down", {31'd0, if_valid}, 32'd0);
    endtask

    // Redirect while a request at old_addr is pending; ack arrives lat cycles later.
    task automatic redirect_pending(input logic j, input logic [25:0] idx, input logic b,
                                    input logic [15:0] imm, input logic [31:0] old_addr,
                                    input int lat, input logic [31:0] new_addr);
        check("rp_req", {31'd0, imem_req}, 32'd1);
        check("rp_old", imem_addr, old_addr);
        jump = j; jump_idx = idx; br_take = b; br_imm = imm; imem_ack = 1'b0;
        @(negedge clk);
        jump = 1'b0; br_take = 1'b0;
        for (int i = 1; i < lat; i++) begin
            check("rp_stable", imem_addr, old_addr);
            @(negedge clk);
        end
        check("rp_stable", imem_addr, old_addr);
        imem_ack   = 1'b1;
        imem_rdata = mem_word(old_addr);
        @(negedge clk);
        imem_ack = 1'b0;
        check("rp_valid", {31'd0, if_valid}, 32'd0);
        check("rp_req2", {31'd0, imem_req}, 32'd1);
        check("rp_new", imem_addr, new_addr);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [63:0] e;
        repeat (2) @(negedge clk);
        check("rst_req", {31'd0, imem_req}, 32'd0);
        check("rst_addr", imem_addr, 32'd0);
        check("rst_valid", {31'd0, if_valid}, 32'd0);
        check("rst_instr", if_instr, 32'd0);
        check("rst_pc4", if_pc4, 32'd0);
        rst_n = 1'b1;
        @(negedge clk);
        check("first_req", {31'd0, imem_req}, 32'd1);
        // zero-wait first fetch, then 5 stalled decode cycles
        fetch_xfer(32'h0, 0, 5);
        for (int a = 4; a <= 16; a += 4) fetch_xfer(a, $urandom_range(0, 2), $urandom_range(0, 2));
        // jump after transfer of pc 0x10, ack one cycle later
        redirect_pending(1'b1, 26'h40, 1'b0, 16'd0, 32'h14, 1, 32'h100);
        fetch_xfer(32'h100, 0, 0);
        redirect_pending(1'b1, 26'h7, 1'b0, 16'd0, 32'h104, 1, 32'h1C);
        fetch_xfer(32'h1C, 0, 0);
        // branch back 8 bytes from last_pc4=0x20, ack three cycles late
        redirect_pending(1'b0, 26'd0, 1'b1, 16'hFFFE, 32'h20, 3, 32'h18);
        fetch_xfer(32'h18, 1, 1);
        // jump while holding an instruction: held word is dropped
        wait_req();
        check("hold_drop_addr", imem_addr, 32'h1C);
        imem_ack   = 1'b1;
        imem_rdata = mem_word(32'h1C);
        exp_q.push_back({mem_word(32'h1C), 32'h20});
        @(negedge clk);
        imem_ack = 1'b0;
        check("hd_valid", {31'd0, if_valid}, 32'd1);
        jump = 1'b1; jump_idx = 26'h80;
        e = exp_q.pop_front();
        @(negedge clk);
        jump = 1'b0;
        check("hd_dropped", {31'd0, if_valid}, 32'd0);
        check("hd_req", {31'd0, imem_req}, 32'd1);
        check("hd_addr", imem_addr, 32'h200);
        fetch_xfer(32'h200, 0, 0);
        // reset in the middle of a pending request
        check("mid_req", {31'd0, imem_req}, 32'd1);
        check("mid_addr", imem_addr, 32'h204);
        rst_n = 1'b0;
        #1;
        check("async_req", {31'd0, imem_req}, 32'd0);
        check("async_valid", {31'd0, if_valid}, 32'd0);
        check("async_addr", imem_addr, 32'd0);
        exp_q.delete();
        @(negedge clk);
        rst_n = 1'b1;
        fetch_xfer(32'h0, 0, 0);
        // wrap instance has fetched its reset word and is holding it
        check("wrap_valid", {31'd0, w_valid}, 32'd1);
        check("wrap_pc4", w_pc4, 32'd0);
        check("wrap_instr", w_instr, mem_word(32'hFFFF_FFFC));
        w_ready = 1'b1;
        @(negedge clk);
        w_ready = 1'b0;
        check("wrap_req", {31'd0, w_req}, 32'd1);
        check("wrap_next", w_addr, 32'd0);
        check("q_empty", exp_q.size(), 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
